// File: rtl/mem_arbiter.sv
// Arbiter for the single main-memory port shared by instruction fetch and the MEM stage.
// Data requests win by default; a saturating starvation counter forces a fetch grant.
module mem_arbiter #(
   parameter int ADDR_W     = 22,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {S_IDLE, S_RD_WAIT} state_e;

   localparam logic [2:0] LAT  = 3'(RD_LAT);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   state_e            state_q;
   logic              owner_q;      // 0 = fetch, 1 = data port
   logic [2:0]        cnt_q;
   logic [3:0]        starve_q, starve_d;
   logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
   logic              if_rvalid_q, dm_rvalid_q;

   logic arb_ok, if_win, dm_win, rd_start, rd_done;

   // Gated by rst so nothing is granted while reset is held.
   assign arb_ok   = rst && (state_q == S_IDLE);
   assign if_win   = arb_ok && if_req && (!dm_req || (starve_q == SMAX));
   assign dm_win   = arb_ok && dm_req && !if_win;
   assign rd_start = if_win || (dm_win && !dm_we);
   assign rd_done  = (state_q == S_RD_WAIT) && (cnt_q == LAT);

   assign if_gnt    = if_win;
   assign dm_gnt    = dm_win;
   assign mem_en    = if_win || dm_win;
   assign mem_we    = dm_win && dm_we;
   assign mem_addr  = if_win ? if_addr : (dm_win ? dm_addr : '0);
   assign mem_wdata = dm_win ? dm_wdata : '0;

   assign if_rvalid = if_rvalid_q;
   assign dm_rvalid = dm_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;

   always_comb begin
      starve_d = starve_q;
      if (!if_req || if_win)
         starve_d = '0;
      else if (dm_win && (starve_q != SMAX))
         starve_d = starve_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         cnt_q       <= '0;
         starve_q    <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
      end else begin
         starve_q    <= starve_d;
         if_rvalid_q <= rd_done && !owner_q;
         dm_rvalid_q <= rd_done && owner_q;
         case (state_q)
            S_IDLE: begin
               if (rd_start) begin
                  state_q <= S_RD_WAIT;
                  owner_q <= dm_win;
                  cnt_q   <= 3'd1;
               end
            end
            S_RD_WAIT: begin
               if (rd_done) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  if (owner_q) dm_rdata_q <= mem_rdata;
                  else         if_rdata_q <= mem_rdata;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT=2 and RD_LAT=1), a cycle-accurate
// transaction model, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        if_req [2], dm_req [2], dm_we [2];
   logic [21:0] if_addr [2], dm_addr [2];
   logic [31:0] dm_wdata [2], mem_rdata [2];
   logic        if_gnt [2], if_rvalid [2], dm_gnt [2], dm_rvalid [2], mem_en [2], mem_we [2];
   logic [31:0] if_rdata [2], dm_rdata [2], mem_wdata [2];
   logic [21:0] mem_addr [2];

   mem_arbiter #(.ADDR_W(22), .DATA_W(32), .RD_LAT(2), .STARVE_MAX(4)) u0 (
      .clk(clk), .rst(rst),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
      .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
      .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
      .dm_gnt(dm_gnt[0]), .dm_rvalid(dm_rvalid[0]), .dm_rdata(dm_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

   mem_arbiter #(.ADDR_W(22), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) u1 (
      .clk(clk), .rst(rst),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
      .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
      .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
      .dm_gnt(dm_gnt[1]), .dm_rvalid(dm_rvalid[1]), .dm_rdata(dm_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

   int n_chk = 0, n_fail = 0, cyc = 0;

   // staged stimulus, applied at the next falling edge
   logic        s_rst;
   logic        s_if_req [2], s_dm_req [2], s_dm_we [2];
   logic [21:0] s_if_addr [2], s_dm_addr [2];
   logic [31:0] s_dm_wdata [2];

   // reference model: at most one read in flight, identified by its grant cycle
   bit          m_live [2], m_own [2], m_ifg [2], m_dmg [2];
   int          m_gc [2], m_starve [2];
   logic [21:0] m_addr [2];
   logic [31:0] m_ifd [2], m_dmd [2];

   function automatic int lat(int g);
      return (g == 0) ? 2 : 1;
   endfunction

   function automatic logic [31:0] memread(logic [21:0] a);
      if (a == 22'h10) return 32'hDEADBEEF;
      return {a[9:0], a} ^ 32'h1234_5678;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      rst = s_rst;
      for (int g = 0; g < 2; g++) begin
         if_req[g] = s_if_req[g];   if_addr[g]  = s_if_addr[g];
         dm_req[g] = s_dm_req[g];   dm_we[g]    = s_dm_we[g];
         dm_addr[g] = s_dm_addr[g]; dm_wdata[g] = s_dm_wdata[g];
         mem_rdata[g] = (m_live[g] && cyc == m_gc[g] + lat(g)) ? memread(m_addr[g]) : $urandom;
      end
      #1;
      for (int g = 0; g < 2; g++) begin
         bit busy, rv, ifw, dmw;
         logic [5:0]  e_ctl;
         logic [21:0] e_addr;
         logic [31:0] e_wd;
         if (!rst) begin
            m_live[g] = 0; m_starve[g] = 0; m_ifd[g] = '0; m_dmd[g] = '0;
            ifw = 0; dmw = 0; e_ctl = '0; e_addr = '0; e_wd = '0;
         end else begin
            busy = m_live[g] && cyc > m_gc[g] && cyc <= m_gc[g] + lat(g);
            rv   = m_live[g] && cyc == m_gc[g] + lat(g) + 1;
            if (rv) begin
               if (m_own[g]) m_dmd[g] = memread(m_addr[g]);
               else          m_ifd[g] = memread(m_addr[g]);
            end
            ifw = !busy && if_req[g] && (!dm_req[g] || m_starve[g] == 4);
            dmw = !busy && dm_req[g] && !ifw;
            e_ctl  = {ifw, dmw, rv && !m_own[g], rv && m_own[g], ifw || dmw, dmw && dm_we[g]};
            e_addr = ifw ? if_addr[g] : (dmw ? dm_addr[g] : '0);
            e_wd   = dmw ? dm_wdata[g] : '0;
            if (ifw || !if_req[g]) m_starve[g] = 0;
            else if (dmw && m_starve[g] < 4) m_starve[g]++;
            if (ifw || (dmw && !dm_we[g])) begin
               m_live[g] = 1; m_gc[g] = cyc; m_own[g] = dmw;
               m_addr[g] = ifw ? if_addr[g] : dm_addr[g];
            end
         end
         chk($sformatf("u%0d ctl{ig,dg,iv,dv,en,we}", g),
             64'({if_gnt[g], dm_gnt[g], if_rvalid[g], dm_rvalid[g], mem_en[g], mem_we[g]}), 64'(e_ctl));
         chk($sformatf("u%0d mem_addr", g),  64'(mem_addr[g]),  64'(e_addr));
         chk($sformatf("u%0d mem_wdata", g), 64'(mem_wdata[g]), 64'(e_wd));
         chk($sformatf("u%0d if_rdata", g),  64'(if_rdata[g]),  64'(m_ifd[g]));
         chk($sformatf("u%0d dm_rdata", g),  64'(dm_rdata[g]),  64'(m_dmd[g]));
         m_ifg[g] = ifw; m_dmg[g] = dmw;
      end
      cyc++;
   endtask

   task automatic idle_all();
      for (int g = 0; g < 2; g++) begin
         s_if_req[g] = 0; s_if_addr[g] = '0; s_dm_req[g] = 0; s_dm_we[g] = 0;
         s_dm_addr[g] = '0; s_dm_wdata[g] = '0;
      end
   endtask

   task automatic stage_if(int g, logic [21:0] a);
      s_if_req[g] = 1; s_if_addr[g] = a;
   endtask

   task automatic stage_dm(int g, logic we, logic [21:0] a, logic [31:0] d);
      s_dm_req[g] = 1; s_dm_we[g] = we; s_dm_addr[g] = a; s_dm_wdata[g] = d;
   endtask

   task automatic rand_stim(int g);
      if (!(s_if_req[g] && !m_ifg[g])) begin
         s_if_req[g] = ($urandom_range(2) == 0); s_if_addr[g] = 22'($urandom);
      end
      if (!(s_dm_req[g] && !m_dmg[g])) begin
         s_dm_req[g] = ($urandom_range(3) != 0); s_dm_we[g] = 1'($urandom);
         s_dm_addr[g] = 22'($urandom); s_dm_wdata[g] = $urandom;
      end
   endtask

   initial begin
      rst = 1'b0;
      s_rst = 1'b0;
      idle_all();
      for (int g = 0; g < 2; g++) begin
         m_live[g] = 0; m_own[g] = 0; m_gc[g] = -100; m_starve[g] = 0;
         m_addr[g] = '0; m_ifd[g] = '0; m_dmd[g] = '0; m_ifg[g] = 0; m_dmg[g] = 0;
      end
      // reset: requests are present but nothing may be granted
      stage_if(0, 22'h5); stage_dm(0, 1'b0, 22'h6, 32'h0);
      cycle();
      chk("lit reset ctl", 64'({if_gnt[0], dm_gnt[0], if_rvalid[0], dm_rvalid[0], mem_en[0]}), 64'(0));
      chk("lit reset rdata", 64'({if_rdata[0], dm_rdata[0]}), 64'(0));
      idle_all(); s_rst = 1'b1;
      cycle();

      // single fetch
      stage_if(0, 22'h10);
      cycle();
      chk("lit fetch gnt/en", 64'({if_gnt[0], mem_en[0], mem_we[0]}), 64'(3'b110));
      chk("lit fetch addr", 64'(mem_addr[0]), 64'(22'h10));
      idle_all();
      cycle(); cycle();
      chk("lit fetch no early rvalid", 64'(if_rvalid[0]), 64'(0));
      cycle();
      chk("lit fetch rvalid", 64'({if_rvalid[0], dm_rvalid[0]}), 64'(2'b10));
      chk("lit fetch rdata", 64'(if_rdata[0]), 64'(32'hDEADBEEF));
      cycle();
      chk("lit fetch rvalid pulse", 64'(if_rvalid[0]), 64'(0));

      // simultaneous requests: data first, fetch after the read returns
      stage_if(0, 22'h40); stage_dm(0, 1'b0, 22'h100, 32'h0);
      cycle();
      chk("lit both gnt", 64'({if_gnt[0], dm_gnt[0]}), 64'(2'b01));
      s_dm_req[0] = 0;
      cycle(); cycle();
      cycle();
      chk("lit both dm_rvalid+if_gnt", 64'({dm_rvalid[0], if_gnt[0]}), 64'(2'b11));
      chk("lit both if addr", 64'(mem_addr[0]), 64'(22'h40));
      idle_all();
      repeat (3) cycle();

      // starvation: four data writes, then fetch is forced
      for (int k = 0; k < 5; k++) begin
         stage_if(0, 22'h55); stage_dm(0, 1'b1, 22'(22'h80 + k), 32'(k));
         cycle();
         chk($sformatf("lit starve gnt %0d", k), 64'({if_gnt[0], dm_gnt[0]}),
             64'((k < 4) ? 2'b01 : 2'b10));
      end
      idle_all();
      repeat (3) cycle();

      // write burst
      for (int k = 0; k < 3; k++) begin
         stage_dm(0, 1'b1, 22'(22'h20 + k), 32'(k + 1));
         cycle();
         chk($sformatf("lit wr burst %0d", k),
             64'({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]}),
             64'({2'b11, 22'(22'h20 + k), 32'(k + 1)}));
      end
      idle_all();
      cycle();

      // reset mid-read discards the read
      stage_if(0, 22'h10);
      cycle();
      chk("lit rst-mid gnt", 64'(if_gnt[0]), 64'(1));
      idle_all(); s_rst = 1'b0;
      cycle();
      chk("lit rst-mid outputs", 64'({if_gnt[0], if_rvalid[0], mem_en[0], mem_addr[0], if_rdata[0]}), 64'(0));
      s_rst = 1'b1; stage_if(0, 22'h30);
      cycle();
      chk("lit rst-mid regrant", 64'({if_gnt[0], mem_addr[0]}), 64'({1'b1, 22'h30}));
      idle_all();
      cycle();
      chk("lit rst-mid no stale rvalid", 64'({if_rvalid[0], if_rdata[0]}), 64'(0));
      repeat (3) cycle();

      // RD_LAT=1: alternating reads, next request waiting through RD_WAIT
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) stage_if(1, 22'(22'h200 + k));
         else            stage_dm(1, 1'b0, 22'(22'h200 + k), 32'h0);
         cycle();
         chk($sformatf("lit lat1 gnt %0d", k), 64'({if_gnt[1], dm_gnt[1]}),
             64'((k % 2 == 0) ? 2'b10 : 2'b01));
         if (k > 0)
            chk($sformatf("lit lat1 rvalid %0d", k - 1), 64'({if_rvalid[1], dm_rvalid[1]}),
                64'((k % 2 == 0) ? 2'b01 : 2'b10));
         idle_all();
         if (k < 5) begin
            if (k % 2 == 0) stage_dm(1, 1'b0, 22'(22'h201 + k), 32'h0);
            else            stage_if(1, 22'(22'h201 + k));
         end
         cycle();
         chk($sformatf("lit lat1 wait %0d", k), 64'({if_gnt[1], dm_gnt[1], mem_en[1]}), 64'(0));
         s_if_req[1] = 0; s_dm_req[1] = 0;
      end
      cycle();
      chk("lit lat1 last rvalid", 64'({if_rvalid[1], dm_rvalid[1]}), 64'(2'b01));
      idle_all();
      cycle();

      // random traffic on both instances with occasional resets
      for (int n = 0; n < 4000; n++) begin
         for (int g = 0; g < 2; g++) rand_stim(g);
         s_rst = ($urandom_range(299) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single main_mem port between instruction fetch (IF, read-only) and the MEM stage (data read/write).
- Sequences multi-cycle reads and returns the data to the requester that owns each read.
- Provides req/gnt/rvalid handshakes; the pipeline stalls a requester while its req is high and gnt is low.
- Data port has priority, with a starvation guard so fetch always makes progress.

Parameters:
ADDR_W, 22, address width (matches the 22-bit PC/memory address space)
DATA_W, 32, data width
RD_LAT, 2, cycles from a granted read (mem_en=1) until mem_rdata is valid; legal range 1..7
STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
if_req  in  1  fetch read request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  combinational accept of fetch request this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetch read data (registered)
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_gnt
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  combinational accept of data request this cycle
dm_rvalid  out  1  one-cycle pulse: dm_rdata valid (reads only)
dm_rdata  out  DATA_W  load data (registered)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en

Behaviour:
- FSM states:
  - IDLE: arbitrate.
  - RD_WAIT: a read is in flight. Holds an owner flag (IF or DM) and a 3-bit latency counter.
- IDLE arbitration, evaluated every cycle:
  - if_req only: grant IF.
  - dm_req only: grant DM.
  - Both: grant DM, unless starve_cnt == STARVE_MAX, in which case grant IF.
- Grant-cycle outputs:
  - gnt and mem_en are asserted combinationally in the same cycle. mem_addr/mem_we/mem_wdata are muxed from the winner.
  - IF grant always has mem_we=0.
  - When no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Writes (DM grant with dm_we=1):
  - Complete in the grant cycle; FSM stays in IDLE; no rvalid.
  - Back-to-back writes sustain 1 per cycle.
- Reads:
  - Grant at cycle T. FSM enters RD_WAIT with counter=1 and owner recorded.
  - Counter increments each cycle. In cycle T+RD_LAT, mem_rdata is captured into the owner's rdata register.
  - Owner's rvalid=1 in cycle T+RD_LAT+1 only. FSM is back in IDLE in that cycle and may grant again.
  - Read throughput: 1 per RD_LAT+1 cycles.
- RD_WAIT: no gnt is asserted, mem_en=0; requests wait.
- rdata registers hold their value until the next read for the same port.
- Starvation counter (starve_cnt, 4-bit):
  - +1 on each DM grant while if_req=1, saturating at STARVE_MAX.
  - Cleared on IF grant, and in any cycle with if_req=0.
- A requester may deassert req before gnt with no side effects. A req still high in the cycle after a grant is a new request.
- Reset (rst=0, asynchronous, any state including mid-read):
  - FSM=IDLE, counter=0, owner=IF, starve_cnt=0.
  - if_rdata=0, dm_rdata=0, all gnt/rvalid/mem_* = 0.
  - An in-flight read is discarded: no rvalid after reset is released.
  - First grant is possible in the first cycle with rst=1.

Test Plan:
- Single fetch, RD_LAT=2: if_req=1, if_addr=0x000010 at T; memory returns 0xDEADBEEF at T+2 -> if_gnt=1 and mem_en=1 at T, if_rvalid=1 with if_rdata=0xDEADBEEF at T+3 only, dm_rvalid stays 0.
- Simultaneous requests: if_req=1 and dm_req=1 (read 0x000100) at T -> dm_gnt=1, if_gnt=0 at T; dm_rvalid at T+3; if_gnt=1 at T+3 with mem_addr=if_addr.
- Starvation, STARVE_MAX=4: if_req held high while dm issues continuous writes -> dm_gnt in 4 consecutive cycles, then if_gnt=1 in the 5th cycle; starve_cnt back to 0.
- Write burst: dm_req=1, dm_we=1 for 3 cycles with addresses 0x20/0x21/0x22 and data 1/2/3 -> mem_en=mem_we=1 in 3 consecutive cycles with matching addr/data; no rvalid pulses.
- Reset mid-read: fetch granted at T, rst=0 at T+1, released at T+2 -> all outputs 0 during reset; if_rvalid never asserts; if_rdata=0; new request granted at T+2.
- RD_LAT=1 sweep: alternating IF/DM reads -> each rvalid arrives 2 cycles after its gnt, routed to the correct port, with no grant issued during RD_WAIT.
